hazard_ctrl_unit: RTL and testbench
===================================

# hazard_ctrl_unit

Parametrised pipeline hazard controller for the 5-stage RISC-V core, sitting between the ID and EX stages. It detects load-use dependencies and stalls for a configurable number of cycles. It also holds the pipeline while a multi-cycle EX unit is busy, and flushes IF/ID and ID/EX on a taken branch or jump. Register x0 is ignored as a dependency source, and stall cycles are counted in a saturating counter.

## Interface
- ADDR_W, 5, register address width
- LOAD_STALL_CYCLES, 1, stall cycles per load-use hazard, legal 1..7
- CNT_W, 16, width of stall_cycles performance counter
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- id_rs1  in  ADDR_W  rs1 of instruction in ID
- id_rs2  in  ADDR_W  rs2 of instruction in ID
- id_rs1_used  in  1  ID instruction reads rs1
- id_rs2_used  in  1  ID instruction reads rs2
- ex_rd  in  ADDR_W  destination of instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_busy  in  1  multi-cycle EX unit not done
- ex_redirect  in  1  taken branch/jump resolved in EX
- perf_clr  in  1  synchronous clear of stall_cycles
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID register loads NOP
- id_ex_write  out  1  ID/EX register enable
- id_ex_flush  out  1  ID/EX register loads bubble
- stall_active  out  1  pc_write==0 this cycle
- stall_cycles  out  CNT_W  saturating stall count

## Operation
- Hazard: `lu = ex_mem_read & (ex_rd!=0) & ((id_rs1_used & ex_rd==id_rs1) | (id_rs2_used & ex_rd==id_rs2))`.
- FSM states:
  - IDLE: normal operation.
  - LSTALL: extra load-use stall cycles. A 3-bit down-counter `rem` tracks the cycles left.
- Outputs are combinational from state and inputs. Priority is redirect > busy > load-use > LSTALL > normal.
- Redirect (any state):
  - if_id_flush=1, id_ex_flush=1, pc_write=1, if_id_write=1, id_ex_write=1.
  - Next state IDLE and rem=0, which aborts any pending load stall.
- Busy (no redirect):
  - pc_write=0, if_id_write=0, id_ex_write=0, both flushes 0.
  - State and rem are frozen.
- Load-use in IDLE (no redirect, no busy):
  - pc_write=0, if_id_write=0, id_ex_write=1, id_ex_flush=1.
  - If LOAD_STALL_CYCLES>1: next state LSTALL with rem=LOAD_STALL_CYCLES-1. Otherwise stay in IDLE.
- LSTALL (no redirect, no busy):
  - Same outputs as load-use; rem decrements.
  - When rem==1, next state IDLE.
  - lu is not re-evaluated during LSTALL.
- Normal: all writes 1, all flushes 0.
- stall_active = ~pc_write.
- stall_cycles:
  - perf_clr: 0 next cycle (wins over increment).
  - Otherwise +1 on each cycle with stall_active=1.
  - Saturates at 2^CNT_W-1 with no wrap.

## Timing
- Reset (async, immediate): state IDLE, rem 0, stall_cycles 0.
- With quiescent inputs during and after reset: pc_write=1, if_id_write=1, id_ex_write=1, flushes 0, stall_active 0.
- Detection is zero-latency: the stall and bubble appear in the same cycle the dependent instruction sits in ID.
- Load-use penalty is exactly LOAD_STALL_CYCLES cycles, plus any busy cycles that overlap it.
- Redirect is a single-cycle, 2-instruction flush with no stall.
- stall_cycles updates one cycle after the stalled cycle.
- If rst is asserted mid-stall, state returns to IDLE immediately and outputs revert to normal in that same cycle.
- ex_rd==0 with ex_mem_read=1 never stalls.
- Operand used-flags at 0 suppress matches.

## Test plan
- **Single-cycle load-use:** LOAD_STALL_CYCLES=1, ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_used=1 for one cycle.
  - Required: exactly 1 cycle with pc_write=0, if_id_write=0, id_ex_flush=1.
  - Required: stall_cycles=1 afterwards.
- **Three-cycle load-use:** LOAD_STALL_CYCLES=3, hazard on rs2 in one cycle, then ex_mem_read=0.
  - Required: 3 consecutive stall cycles (IDLE→LSTALL rem 2→1→IDLE), then normal.
  - Required: stall_cycles=3.
- **x0 and unused-operand filter:** ex_rd=0 matching id_rs1=0, then ex_rd=7 with id_rs2=7 and id_rs2_used=0.
  - Required: no stall in either case; all writes 1.
- **Busy and redirect interactions:**
  - Stimulus: ex_busy=1 for 4 cycles starting at LSTALL rem=2. Required: 4 cycles of all writes 0 with rem held, then 2 more load-stall cycles.
  - Stimulus: ex_redirect=1 during LSTALL. Required: both flushes 1, pc_write=1, and state IDLE on the next edge.
- **Counter saturation:** CNT_W=4, 20 consecutive busy cycles.
  - Required: stall_cycles stops at 15.
  - Required: perf_clr together with stall_active gives 0 on the next cycle.
- **Async reset:** assert rst mid-LSTALL with no clock edge.
  - Required: outputs return immediately to pc_write=1 and flushes 0.
  - Required: stall_cycles=0.

Source files
------------

// File: rtl/hazard_ctrl_unit.sv
// Load-use / busy / redirect hazard control between the ID and EX stages.
// Pipeline enables and flushes are combinational; a small FSM stretches load-use stalls.
module hazard_ctrl_unit #(
  parameter int ADDR_W            = 5,
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] id_rs1_i,
  input  logic [ADDR_W-1:0] id_rs2_i,
  input  logic              id_rs1_used_i,
  input  logic              id_rs2_used_i,
  input  logic [ADDR_W-1:0] ex_rd_i,
  input  logic              ex_mem_read_i,
  input  logic              ex_busy_i,
  input  logic              ex_redirect_i,
  input  logic              perf_clr_i,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic              if_id_flush_o,
  output logic              id_ex_write_o,
  output logic              id_ex_flush_o,
  output logic              stall_active_o,
  output logic [CNT_W-1:0]  stall_cycles_o
);

  typedef enum logic {
    S_IDLE,
    S_LSTALL
  } state_e;

  localparam bit       MULTI_STALL = (LOAD_STALL_CYCLES > 1);
  localparam logic [2:0] REM_INIT  = 3'(LOAD_STALL_CYCLES - 1);

  state_e           state_q, state_d;
  logic [2:0]       rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu;
  logic             rs1_hit, rs2_hit;

  // x0 is hard-wired zero, so a load targeting it never creates a dependency.
  assign rs1_hit = id_rs1_used_i && (ex_rd_i == id_rs1_i);
  assign rs2_hit = id_rs2_used_i && (ex_rd_i == id_rs2_i);
  assign lu      = ex_mem_read_i && (ex_rd_i != '0) && (rs1_hit || rs2_hit);

  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    pc_write_o    = 1'b1;
    if_id_write_o = 1'b1;
    if_id_flush_o = 1'b0;
    id_ex_write_o = 1'b1;
    id_ex_flush_o = 1'b0;

    if (ex_redirect_i) begin
      if_id_flush_o = 1'b1;
      id_ex_flush_o = 1'b1;
      state_d       = S_IDLE;
      rem_d         = 3'd0;
    end else if (ex_busy_i) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      id_ex_write_o = 1'b0;
    end else if (state_q == S_LSTALL) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      id_ex_flush_o = 1'b1;
      rem_d         = rem_q - 3'd1;
      if (rem_q == 3'd1) begin
        state_d = S_IDLE;
      end
    end else if (lu) begin
      pc_write_o    = 1'b0;
      if_id_write_o = 1'b0;
      id_ex_flush_o = 1'b1;
      if (MULTI_STALL) begin
        state_d = S_LSTALL;
        rem_d   = REM_INIT;
      end
    end
  end

  assign stall_active_o = ~pc_write_o;

  always_comb begin
    cnt_d = cnt_q;
    if (perf_clr_i) begin
      cnt_d = '0;
    end else if (stall_active_o && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      rem_q   <= 3'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_cycles_o = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit: three instances share stimulus
// (1-cycle load stall, 3-cycle load stall, 3-cycle with a 4-bit counter).
module tb_hazard_ctrl_unit;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [4:0] id_rs1_i, id_rs2_i, ex_rd_i;
  logic       id_rs1_used_i, id_rs2_used_i;
  logic       ex_mem_read_i, ex_busy_i, ex_redirect_i, perf_clr_i;

  logic        a_pc, a_ifw, a_iff, a_idw, a_idf, a_sa;
  logic [15:0] a_cnt;
  logic        b_pc, b_ifw, b_iff, b_idw, b_idf, b_sa;
  logic [15:0] b_cnt;
  logic        c_pc, c_ifw, c_iff, c_idw, c_idf, c_sa;
  logic [3:0]  c_cnt;

  logic [5:0] a_o, b_o, c_o;
  assign a_o = {a_pc, a_ifw, a_iff, a_idw, a_idf, a_sa};
  assign b_o = {b_pc, b_ifw, b_iff, b_idw, b_idf, b_sa};
  assign c_o = {c_pc, c_ifw, c_iff, c_idw, c_idf, c_sa};

  // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, stall_active}
  localparam logic [5:0] NORM  = 6'b110100;
  localparam logic [5:0] LUST  = 6'b000111;
  localparam logic [5:0] BUSY  = 6'b000001;
  localparam logic [5:0] REDIR = 6'b111110;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  hazard_ctrl_unit #(.ADDR_W(5), .LOAD_STALL_CYCLES(1), .CNT_W(16)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .ex_rd_i(ex_rd_i), .ex_mem_read_i(ex_mem_read_i),
    .ex_busy_i(ex_busy_i), .ex_redirect_i(ex_redirect_i), .perf_clr_i(perf_clr_i),
    .pc_write_o(a_pc), .if_id_write_o(a_ifw), .if_id_flush_o(a_iff),
    .id_ex_write_o(a_idw), .id_ex_flush_o(a_idf),
    .stall_active_o(a_sa), .stall_cycles_o(a_cnt)
  );

  hazard_ctrl_unit #(.ADDR_W(5), .LOAD_STALL_CYCLES(3), .CNT_W(16)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .ex_rd_i(ex_rd_i), .ex_mem_read_i(ex_mem_read_i),
    .ex_busy_i(ex_busy_i), .ex_redirect_i(ex_redirect_i), .perf_clr_i(perf_clr_i),
    .pc_write_o(b_pc), .if_id_write_o(b_ifw), .if_id_flush_o(b_iff),
    .id_ex_write_o(b_idw), .id_ex_flush_o(b_idf),
    .stall_active_o(b_sa), .stall_cycles_o(b_cnt)
  );

  hazard_ctrl_unit #(.ADDR_W(5), .LOAD_STALL_CYCLES(3), .CNT_W(4)) dut_c (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .ex_rd_i(ex_rd_i), .ex_mem_read_i(ex_mem_read_i),
    .ex_busy_i(ex_busy_i), .ex_redirect_i(ex_redirect_i), .perf_clr_i(perf_clr_i),
    .pc_write_o(c_pc), .if_id_write_o(c_ifw), .if_id_flush_o(c_iff),
    .id_ex_write_o(c_idw), .id_ex_flush_o(c_idf),
    .stall_active_o(c_sa), .stall_cycles_o(c_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic quiet();
    id_rs1_i      = 5'd0;
    id_rs2_i      = 5'd0;
    ex_rd_i       = 5'd0;
    id_rs1_used_i = 1'b0;
    id_rs2_used_i = 1'b0;
    ex_mem_read_i = 1'b0;
    ex_busy_i     = 1'b0;
    ex_redirect_i = 1'b0;
    perf_clr_i    = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    quiet();
    #4;
    rst_i = 1'b0;
    tick();
  endtask

  task automatic load_use_rs1(input logic [4:0] r);
    ex_mem_read_i = 1'b1;
    ex_rd_i       = r;
    id_rs1_i      = r;
    id_rs1_used_i = 1'b1;
  endtask

  initial begin
    rst_i = 1'b1;
    quiet();
    #1;
    chk("rst_outs_a", 32'(a_o), 32'(NORM));
    chk("rst_cnt_a", 32'(a_cnt), 32'd0);
    do_reset();
    chk("post_rst_outs_b", 32'(b_o), 32'(NORM));
    chk("post_rst_cnt_b", 32'(b_cnt), 32'd0);

    // single-cycle load-use (dut_a); dut_b runs the 3-cycle version alongside
    load_use_rs1(5'd5);
    #1;
    chk("lu1_stall_a", 32'(a_o), 32'(LUST));
    chk("lu1_stall_b", 32'(b_o), 32'(LUST));
    tick();
    quiet();
    #1;
    chk("lu1_after_a", 32'(a_o), 32'(NORM));
    chk("lu1_cnt_a", 32'(a_cnt), 32'd1);
    chk("lu3_rem2_b", 32'(b_o), 32'(LUST));
    tick();
    chk("lu3_rem1_b", 32'(b_o), 32'(LUST));
    tick();
    chk("lu3_done_b", 32'(b_o), 32'(NORM));
    chk("lu3_cnt_b", 32'(b_cnt), 32'd3);
    chk("lu1_cnt_hold_a", 32'(a_cnt), 32'd1);

    // three-cycle load-use on rs2
    do_reset();
    ex_mem_read_i = 1'b1;
    ex_rd_i       = 5'd9;
    id_rs2_i      = 5'd9;
    id_rs2_used_i = 1'b1;
    id_rs1_i      = 5'd3;
    id_rs1_used_i = 1'b1;
    #1;
    chk("rs2_c1_b", 32'(b_o), 32'(LUST));
    tick();
    quiet();
    #1;
    chk("rs2_c2_b", 32'(b_o), 32'(LUST));
    tick();
    chk("rs2_c3_b", 32'(b_o), 32'(LUST));
    tick();
    chk("rs2_norm_b", 32'(b_o), 32'(NORM));
    chk("rs2_cnt_b", 32'(b_cnt), 32'd3);

    // x0 and unused-operand filters
    do_reset();
    load_use_rs1(5'd0);
    #1;
    chk("x0_a", 32'(a_o), 32'(NORM));
    chk("x0_b", 32'(b_o), 32'(NORM));
    tick();
    ex_rd_i       = 5'd7;
    id_rs2_i      = 5'd7;
    id_rs2_used_i = 1'b0;
    id_rs1_i      = 5'd3;
    #1;
    chk("unused_rs2_b", 32'(b_o), 32'(NORM));
    tick();
    quiet();
    #1;
    chk("filter_cnt_b", 32'(b_cnt), 32'd0);

    // busy freezes LSTALL at rem=2
    do_reset();
    load_use_rs1(5'd12);
    #1;
    chk("busy_lu_b", 32'(b_o), 32'(LUST));
    tick();
    quiet();
    ex_busy_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("busy_%0d_b", i), 32'(b_o), 32'(BUSY));
      tick();
    end
    ex_busy_i = 1'b0;
    #1;
    chk("busy_rem2_b", 32'(b_o), 32'(LUST));
    tick();
    chk("busy_rem1_b", 32'(b_o), 32'(LUST));
    tick();
    chk("busy_norm_b", 32'(b_o), 32'(NORM));
    chk("busy_cnt_b", 32'(b_cnt), 32'd7);
    chk("busy_cnt_a", 32'(a_cnt), 32'd5);

    // redirect during LSTALL
    do_reset();
    load_use_rs1(5'd4);
    tick();
    quiet();
    ex_redirect_i = 1'b1;
    #1;
    chk("redir_b", 32'(b_o), 32'(REDIR));
    tick();
    ex_redirect_i = 1'b0;
    #1;
    chk("redir_idle_b", 32'(b_o), 32'(NORM));
    chk("redir_cnt_b", 32'(b_cnt), 32'd1);

    // 4-bit counter saturation and clear
    do_reset();
    ex_busy_i = 1'b1;
    repeat (20) tick();
    chk("sat_c", 32'(c_cnt), 32'd15);
    chk("nosat_b", 32'(b_cnt), 32'd20);
    perf_clr_i = 1'b1;
    #1;
    chk("clr_sa_c", 32'(c_sa), 32'd1);
    tick();
    chk("clr_c", 32'(c_cnt), 32'd0);
    perf_clr_i = 1'b0;
    tick();
    chk("clr_inc_c", 32'(c_cnt), 32'd1);
    ex_busy_i = 1'b0;

    // async reset mid-LSTALL
    do_reset();
    load_use_rs1(5'd6);
    tick();
    quiet();
    #1;
    chk("arst_pre_b", 32'(b_o), 32'(LUST));
    rst_i = 1'b1;
    #1;
    chk("arst_outs_b", 32'(b_o), 32'(NORM));
    chk("arst_cnt_b", 32'(b_cnt), 32'd0);
    rst_i = 1'b0;
    tick();
    chk("arst_after_b", 32'(b_o), 32'(NORM));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
